// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan chain controller.
// The optional MISR (enabled with SCAN_CTRL_MISR_EN) takes its feedback taps from here.
package scan_ctrl_pkg;

    // Controller sequence states
    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        UNLOAD,
        DONE
    } state_e;

    // Galois MISR feedback taps, LSB-aligned; the low CHAIN_LEN bits are used.
    // The 8-bit value is x^8 + x^4 + x^3 + x^2 + 1.
    localparam logic [31:0] MISR_POLY = 32'h0000_001D;

    // Width of the per-phase cell counter; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/scan_ctrl_misr.sv
// Multiple-input signature register folding the unloaded scan stream into a
// WIDTH-bit signature. It clears only on reset, so it accumulates across patterns.
// It is used only when SCAN_CTRL_MISR_EN is defined.
module scan_ctrl_misr
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rn_i,
    input  logic             en_i,
    input  logic             din_i,
    output logic [WIDTH-1:0] sig_o,
    output logic [WIDTH-1:0] sig_nxt_o
);

    localparam logic [WIDTH-1:0] POLY = MISR_POLY[WIDTH-1:0];

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    // Next signature: shift, conditional polynomial feedback, then fold in the data bit
    always_comb begin
        sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0);
        sig_d[0] = sig_d[0] ^ din_i;
    end

    // Signature register; the value is updated only while unloading
    always_ff @(posedge clk_i) begin
        if (!rn_i) begin
            sig_q <= '0;
        end else if (en_i) begin
            sig_q <= sig_d;
        end
    end

    assign sig_o     = sig_q;
    assign sig_nxt_o = sig_d;

endmodule

// File: rtl/scan_chain_ctrl.sv
// On-chip scan test master for a single mux-D scan chain.
// Each pattern is loaded MSB-first through SD, given one capture cycle, and then unloaded from
// the last cell's Q into a parallel response.
// Build option SCAN_CTRL_MISR_EN adds a signature register and the sig_out port.
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN = 8,
    parameter logic        FILL_BIT  = 1'b0
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pat_in,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] resp_out,
`ifdef SCAN_CTRL_MISR_EN
    output logic [CHAIN_LEN-1:0] sig_out,
`endif
    output logic                 scan_se,
    output logic                 scan_sd,
    input  logic                 scan_so
);

    localparam int unsigned     CW       = cnt_width(CHAIN_LEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(CHAIN_LEN - 1);

    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [CHAIN_LEN-1:0]   pat_q;
    logic [CHAIN_LEN-1:0]   resp_sh_q;
    logic [CHAIN_LEN-1:0]   resp_sh_d;
    logic [CHAIN_LEN-1:0]   resp_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   se_q;
    logic                   sd_q;

    // The unloaded bits enter at the LSB, so the first bit (cell CHAIN_LEN-1) ends at the MSB
    always_comb begin
        resp_sh_d = {resp_sh_q[CHAIN_LEN-2:0], scan_so};
    end

`ifdef SCAN_CTRL_MISR_EN
    logic [CHAIN_LEN-1:0] misr_sig;
    logic [CHAIN_LEN-1:0] misr_nxt;
    logic [CHAIN_LEN-1:0] sig_q;

    scan_ctrl_misr #(
        .WIDTH (CHAIN_LEN)
    ) u_misr (
        .clk_i     (CK),
        .rn_i      (RN),
        .en_i      (state_q == UNLOAD),
        .din_i     (scan_so),
        .sig_o     (misr_sig),
        .sig_nxt_o (misr_nxt)
    );

    // Publish the signature at the same edge as resp_out, including the last unloaded bit
    always_ff @(posedge CK) begin
        if (!RN) begin
            sig_q <= '0;
        end else if (state_q == UNLOAD && cnt_q == CNT_LAST) begin
            sig_q <= misr_nxt;
        end
    end

    assign sig_out = sig_q;
`endif

    // Sequencing FSM with registered scan and handshake outputs
    always_ff @(posedge CK) begin
        if (!RN) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pat_q     <= '0;
            resp_sh_q <= '0;
            resp_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            se_q      <= 1'b0;
            sd_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // The MSB goes out in the first shift cycle; the rest stays queued
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        pat_q   <= pat_in << 1;
                        busy_q  <= 1'b1;
                        se_q    <= 1'b1;
                        sd_q    <= pat_in[CHAIN_LEN-1];
                    end
                end
                SHIFT: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= CAPTURE;
                        cnt_q   <= '0;
                        se_q    <= 1'b0;
                        sd_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        sd_q  <= pat_q[CHAIN_LEN-1];
                        pat_q <= pat_q << 1;
                    end
                end
                CAPTURE: begin
                    state_q <= UNLOAD;
                    cnt_q   <= '0;
                    se_q    <= 1'b1;
                    sd_q    <= FILL_BIT;
                end
                UNLOAD: begin
                    resp_sh_q <= resp_sh_d;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        resp_q  <= resp_sh_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        se_q    <= 1'b0;
                        sd_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    se_q    <= 1'b0;
                    sd_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign resp_out = resp_q;
    assign scan_se  = se_q;
    assign scan_sd  = sd_q;

endmodule
